// File: rtl/rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// rom_fetch_unit
//   Instruction-byte prefetcher sitting between the 8051 program ROM
//   (16-bit address, one-cycle registered read) and the decoder.
//   The fetch PC drives the ROM address directly. A one-deep "inflight"
//   stage absorbs the ROM read latency. Returned bytes are queued together
//   with their addresses and handed to the decoder over valid/ready.
//   A redirect flushes queued and in-flight bytes and restarts fetch at the
//   new address.
//
// Optional feature macro: FETCH_STATS_EN
//   defined   -> discard_count counts bytes thrown away by redirects
//                (saturating, cleared only by reset)
//   undefined -> discard_count is tied to zero
//
// Ports
//   clock          in   1   clock, all state updates on posedge
//   reset          in   1   asynchronous active-high reset
//   rom_addr       out  16  ROM address (registered fetch PC)
//   rom_data       in   8   ROM data, valid the cycle after an issue
//   fetch_en       in   1   0 = stop issuing new reads
//   redirect_valid in   1   flush and restart at redirect_addr
//   redirect_addr  in   16  restart address
//   out_valid      out  1   head of queue holds a byte
//   out_byte       out  8   head byte
//   out_pc         out  16  address of head byte
//   out_ready      in   1   decoder takes head when out_valid & out_ready
//   discard_count  out  16  bytes flushed by redirects (see macro above)
// ---------------------------------------------------------------------------
module rom_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic [15:0] out_pc,
    input  logic        out_ready,
    output logic [15:0] discard_count
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  data;
    } entry_t;

    entry_t [FIFO_DEPTH-1:0] mem_q;
    logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic [15:0]             fetch_pc_q, fetch_pc_d;
    logic                    inflight_q, inflight_d;
    logic [15:0]             inflight_pc_q, inflight_pc_d;
    logic                    push, pop, issue;
    logic [CW:0]             credit_used;

    // Queue slots already claimed: stored bytes plus the one still in the ROM.
    // Issuing only while this is below the depth guarantees every landing
    // byte has a free slot, so push never needs a full check.
    assign credit_used = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign push        = inflight_q;
    assign pop         = out_valid & out_ready;
    assign issue       = fetch_en & ~redirect_valid
                       & (credit_used < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        if (redirect_valid) begin
            // Redirect wins over push/pop/issue; the landing byte is dropped.
            fetch_pc_d = redirect_addr;
            count_d    = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 16'd1;  // wraps FFFF -> 0000
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= '{pc: inflight_pc_q, data: rom_data};
                    wr_ptr_q        <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    assign rom_addr  = fetch_pc_q;
    assign out_valid = (count_q != '0);
    // When empty the head slot just shows stale contents.
    assign out_byte  = mem_q[rd_ptr_q].data;
    assign out_pc    = mem_q[rd_ptr_q].pc;

`ifdef FETCH_STATS_EN
    logic [15:0] discard_q, discard_d;
    logic [CW:0] flushed;
    logic [16:0] disc_sum;

    // A byte popped in the redirect cycle counts as consumed, not flushed.
    assign flushed  = {1'b0, count_q} - (CW+1)'(pop) + (CW+1)'(inflight_q);
    assign disc_sum = {1'b0, discard_q} + 17'(flushed);

    always_comb begin
        discard_d = discard_q;
        if (redirect_valid) begin
            discard_d = disc_sum[16] ? 16'hFFFF : disc_sum[15:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            discard_q <= '0;
        end else begin
            discard_q <= discard_d;
        end
    end

    assign discard_count = discard_q;
`else
    assign discard_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
module tb_rom_fetch_unit;

    localparam int DEPTH = 4;
`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic [15:0] out_pc;
    logic        out_ready = 1'b0;
    logic [15:0] discard_count;

    int n_checks = 0;
    int n_errors = 0;

    rom_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_byte       (out_byte),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .discard_count  (discard_count)
    );

    always #5 clock = ~clock;

    // Program ROM: one-cycle registered read.
    logic [7:0] rom [0:65535];
    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The fetch stream as a queue of {pc, byte}, the address being fetched,
    // at most one read outstanding in the ROM, and a flush tally.
    logic [23:0] m_q[$];
    logic [15:0] m_pc = 16'h0000;
    bit          m_inf = 1'b0;
    logic [15:0] m_inf_pc = 16'h0000;
    int          m_dc = 0;

    always @(posedge clock or posedge reset) begin
        int sz;
        bit pop, iss;
        int unsigned tmp;
        if (reset) begin
            m_q.delete();
            m_pc  = 16'h0000;
            m_inf = 1'b0;
            m_dc  = 0;
        end else begin
            sz  = m_q.size();
            pop = (sz != 0) && out_ready;
            if (redirect_valid) begin
                if (STATS) begin
                    tmp  = m_dc + sz - int'(pop) + int'(m_inf);
                    m_dc = (tmp > 65535) ? 65535 : int'(tmp);
                end
                m_q.delete();
                m_inf = 1'b0;
                m_pc  = redirect_addr;
            end else begin
                iss = fetch_en && (sz + int'(m_inf) < DEPTH);
                if (pop) void'(m_q.pop_front());
                if (m_inf) m_q.push_back({m_inf_pc, rom[m_inf_pc]});
                m_inf = iss;
                if (iss) begin
                    m_inf_pc = m_pc;
                    m_pc     = m_pc + 16'd1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            chk("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("m_pc", 32'(out_pc), 32'(m_q[0][23:8]));
                chk("m_byte", 32'(out_byte), 32'(m_q[0][7:0]));
            end
            chk("m_addr", 32'(rom_addr), 32'(m_pc));
            chk("m_disc", 32'(discard_count), 32'(m_dc));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
        rom[0] = 8'h02; rom[1] = 8'h00; rom[2] = 8'h30; rom[3] = 8'hE4;

        repeat (2) cyc();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_byte", 32'(out_byte), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_disc", 32'(discard_count), 32'd0);

        // 1: first bytes after reset
        fetch_en = 1'b1; out_ready = 1'b1; reset = 1'b0;
        cyc(); chk("t1_lat", 32'(out_valid), 32'd0);
        cyc(); chk("t1_v0", 32'(out_valid), 32'd1);
        chk("t1_b0", 32'(out_byte), 32'h02); chk("t1_p0", 32'(out_pc), 32'h0000);
        cyc(); chk("t1_b1", 32'(out_byte), 32'h00); chk("t1_p1", 32'(out_pc), 32'h0001);
        cyc(); chk("t1_b2", 32'(out_byte), 32'h30); chk("t1_p2", 32'(out_pc), 32'h0002);
        cyc(); chk("t1_b3", 32'(out_byte), 32'hE4); chk("t1_p3", 32'(out_pc), 32'h0003);

        // 2: backpressure fills exactly FIFO_DEPTH bytes
        reset = 1'b1; cyc(); reset = 1'b0; out_ready = 1'b0;
        repeat (10) cyc();
        chk("t2_addr", 32'(rom_addr), 32'h0004);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_valid", 32'(out_valid), 32'd1);
            chk("t2_pc", 32'(out_pc), 32'(i));
            cyc();
        end

        // 3: redirect from steady stream
        reset = 1'b1; cyc(); reset = 1'b0;
        repeat (6) cyc();
        redirect_valid = 1'b1; redirect_addr = 16'h0030;
        cyc(); redirect_valid = 1'b0;
        chk("t3_flush", 32'(out_valid), 32'd0);
        chk("t3_addr", 32'(rom_addr), 32'h0030);
        chk("t3_disc", 32'(discard_count), STATS ? 32'd1 : 32'd0);
        cyc(); chk("t3_gap", 32'(out_valid), 32'd0);
        cyc(); chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_pc", 32'(out_pc), 32'h0030);

        // fill the queue, then redirect to FFFE with 4 bytes flushed
        out_ready = 1'b0;
        repeat (10) cyc();
        redirect_valid = 1'b1; redirect_addr = 16'hFFFE;
        cyc(); redirect_valid = 1'b0; out_ready = 1'b1;
        chk("t4_disc", 32'(discard_count), STATS ? 32'd5 : 32'd0);
        chk("t4_addr", 32'(rom_addr), 32'hFFFE);
        cyc();
        cyc(); chk("t4_p0", 32'(out_pc), 32'hFFFE);
        cyc(); chk("t4_p1", 32'(out_pc), 32'hFFFF);
        cyc(); chk("t4_p2", 32'(out_pc), 32'h0000);
        cyc(); chk("t4_p3", 32'(out_pc), 32'h0001);

        // 5: fetch_en low -> only the in-flight byte appears
        fetch_en = 1'b0;
        cyc(); chk("t5_last_v", 32'(out_valid), 32'd1);
        chk("t5_last_pc", 32'(out_pc), 32'h0002);
        cyc(); chk("t5_drain", 32'(out_valid), 32'd0);
        cyc(); chk("t5_idle", 32'(out_valid), 32'd0);
        chk("t5_addr", 32'(rom_addr), 32'h0003);
        fetch_en = 1'b1;
        cyc(); chk("t5_res0", 32'(out_valid), 32'd0);
        cyc(); chk("t5_res_v", 32'(out_valid), 32'd1);
        chk("t5_res_pc", 32'(out_pc), 32'h0003);

        // 6: asynchronous reset with queue half full
        out_ready = 1'b0;
        cyc();
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_addr", 32'(rom_addr), 32'h0000);
        chk("t6_disc", 32'(discard_count), 32'd0);
        cyc(); reset = 1'b0;
        cyc(); chk("t6_lat", 32'(out_valid), 32'd0);
        cyc(); chk("t6_v", 32'(out_valid), 32'd1);
        chk("t6_pc", 32'(out_pc), 32'h0000);
        chk("t6_b", 32'(out_byte), 32'h02);

        // randomized traffic checked against the model
        for (int i = 0; i < 3000; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                         : 16'($urandom);
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            cyc();
            reset = 1'b0;
        end
        redirect_valid = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
